// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: operand forwarding, load-use stalls,
// branch/jump flushes and an external whole-pipeline hold, with event counters.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_valid,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       dm_rd,
  input  logic             dm_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken_ex,
  input  logic             jump_id,
  input  logic             stall_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [1:0] FL_RELOAD   = 2'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_t           r_state;
  state_t           r_ret_state;
  logic [1:0]       r_flush_left;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_lu;
  logic             w_unused;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The EX-stage write enable plays no part in hazard detection.
  assign w_unused = ex_reg_write;

  assign w_lu = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs) || (ex_rd == id_rt));

  assign state       = r_state;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

  // Operand forwarding: the younger EX/DM result beats the DM/WB result.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (reset) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end else begin
      if (dm_reg_write && (dm_rd != 5'd0) && (dm_rd == ex_rs))      fwd_a = 2'b10;
      else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs)) fwd_a = 2'b01;
      else                                                          fwd_a = 2'b00;
      if (dm_reg_write && (dm_rd != 5'd0) && (dm_rd == ex_rt))      fwd_b = 2'b10;
      else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rt)) fwd_b = 2'b01;
      else                                                          fwd_b = 2'b00;
    end
  end

  // Mealy pipeline controls from current state and this cycle's requests.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (stall_req) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
          end else if (branch_taken_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (jump_id) begin
            if_id_flush = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        FLUSH: begin
          if (stall_req) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
          end else begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        HOLD: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  // State, flush countdown, return state and statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_ret_state  <= RUN;
      r_flush_left <= 2'd0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (stall_req) begin
            r_state     <= HOLD;
            r_ret_state <= RUN;
          end else if (branch_taken_ex) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
            if (MULTI_FLUSH) begin
              r_state      <= FLUSH;
              r_flush_left <= FL_RELOAD;
            end
          end else if (w_lu) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
          end
        end
        FLUSH: begin
          if (stall_req) begin
            r_state     <= HOLD;
            r_ret_state <= FLUSH;
          end else if (branch_taken_ex) begin
            r_flush_cnt  <= sat_inc(r_flush_cnt);
            r_flush_left <= FL_RELOAD;
          end else if (r_flush_left <= 2'd1) begin
            r_state      <= RUN;
            r_flush_left <= 2'd0;
          end else begin
            r_flush_left <= r_flush_left - 2'd1;
          end
        end
        HOLD: begin
          if (!stall_req) r_state <= r_ret_state;
        end
        default: begin
          r_state      <= RUN;
          r_flush_left <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, 4-bit counters);
// expectations are queued per cycle and checked by an independent monitor.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;
  localparam logic [1:0] S_RUN = 2'b00, S_FLUSH = 2'b01, S_HOLD = 2'b10;

  typedef struct packed {
    logic          pcw;
    logic          ifw;
    logic          fl;
    logic          bub;
    logic          hold;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, dm_rd, wb_rd;
  logic id_valid, ex_mem_read, ex_reg_write, dm_reg_write, wb_reg_write;
  logic branch_taken_ex, jump_id, stall_req;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
  logic [1:0] fwd_a, fwd_b, state;
  logic [CW-1:0] stall_count, flush_count;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .dm_rd(dm_rd), .dm_reg_write(dm_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken_ex(branch_taken_ex), .jump_id(jump_id), .stall_req(stall_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic pcw, ifw, fl, bub, hold,
                              input logic [1:0] fa, fb, st,
                              input int sc, fc);
    exp_t e;
    e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.bub = bub; e.hold = hold;
    e.fa = fa; e.fb = fb; e.st = st;
    e.sc = CW'(sc); e.fc = CW'(fc);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    id_rs = 5'd0; id_rt = 5'd0; id_valid = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    dm_rd = 5'd0; dm_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
    branch_taken_ex = 1'b0; jump_id = 1'b0; stall_req = 1'b0;
  endtask

  task automatic push(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd; id_rs = rs; id_rt = rt;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
               fwd_a, fwd_b, state, stall_count, flush_count};
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL %s: got pcw=%b ifw=%b fl=%b bub=%b hold=%b fa=%b fb=%b st=%b sc=%0d fc=%0d, want pcw=%b ifw=%b fl=%b bub=%b hold=%b fa=%b fb=%b st=%b sc=%0d fc=%0d",
                   nm, a.pcw, a.ifw, a.fl, a.bub, a.hold, a.fa, a.fb, a.st, a.sc, a.fc,
                   e.pcw, e.ifw, e.fl, e.bub, e.hold, e.fa, e.fb, e.st, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    cyc();
    dm_reg_write = 1'b1; dm_rd = 5'd5; ex_rs = 5'd5; stall_req = 1'b1; set_lu(5'd2, 5'd2, 5'd0);
    push("reset_outputs", mk(0,0,0,0,0, 2'b00,2'b00, S_RUN, 0,0));
    cyc(); reset = 1'b0;
    push("idle_defaults", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 0,0));

    cyc(); set_lu(5'd2, 5'd2, 5'd0);
    push("lu_rs", mk(0,0,0,1,0, 2'b00,2'b00, S_RUN, 0,0));
    cyc();
    push("after_lu", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 1,0));
    cyc(); set_lu(5'd7, 5'd3, 5'd7);
    push("lu_rt", mk(0,0,0,1,0, 2'b00,2'b00, S_RUN, 1,0));
    cyc(); set_lu(5'd0, 5'd0, 5'd0);
    push("lu_r0", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 2,0));
    cyc(); set_lu(5'd4, 5'd4, 5'd0); id_valid = 1'b0;
    push("lu_not_valid", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 2,0));
    cyc(); set_lu(5'd4, 5'd4, 5'd0); ex_mem_read = 1'b0; ex_reg_write = 1'b1;
    push("lu_not_load", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 2,0));

    cyc(); dm_rd = 5'd5; wb_rd = 5'd5; dm_reg_write = 1'b1; wb_reg_write = 1'b1; ex_rs = 5'd5; ex_rt = 5'd9;
    push("fwd_dm_wins", mk(1,1,0,0,0, 2'b10,2'b00, S_RUN, 2,0));
    cyc(); dm_rd = 5'd5; wb_rd = 5'd5; wb_reg_write = 1'b1; ex_rs = 5'd5;
    push("fwd_wb", mk(1,1,0,0,0, 2'b01,2'b00, S_RUN, 2,0));
    cyc(); dm_reg_write = 1'b1; wb_reg_write = 1'b1;
    push("fwd_r0", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 2,0));
    cyc(); dm_rd = 5'd3; dm_reg_write = 1'b1; ex_rt = 5'd3; wb_rd = 5'd4; wb_reg_write = 1'b1; ex_rs = 5'd4;
    push("fwd_mixed", mk(1,1,0,0,0, 2'b01,2'b10, S_RUN, 2,0));

    cyc(); jump_id = 1'b1;
    push("jump", mk(1,1,1,0,0, 2'b00,2'b00, S_RUN, 2,0));
    cyc(); jump_id = 1'b1; set_lu(5'd6, 5'd6, 5'd0);
    push("lu_over_jump", mk(0,0,0,1,0, 2'b00,2'b00, S_RUN, 2,0));

    cyc(); branch_taken_ex = 1'b1;
    push("br_run", mk(1,1,1,1,0, 2'b00,2'b00, S_RUN, 3,0));
    cyc();
    push("br_flush1", mk(1,1,1,1,0, 2'b00,2'b00, S_FLUSH, 3,1));
    cyc(); jump_id = 1'b1; set_lu(5'd8, 5'd8, 5'd0);
    push("br_flush2_ign", mk(1,1,1,1,0, 2'b00,2'b00, S_FLUSH, 3,1));
    cyc();
    push("br_back_run", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 3,1));

    cyc(); branch_taken_ex = 1'b1; set_lu(5'd9, 5'd9, 5'd0);
    push("br_and_lu", mk(1,1,1,1,0, 2'b00,2'b00, S_RUN, 3,1));
    cyc(); branch_taken_ex = 1'b1;
    push("br_in_flush", mk(1,1,1,1,0, 2'b00,2'b00, S_FLUSH, 3,2));
    cyc();
    push("flush_left2", mk(1,1,1,1,0, 2'b00,2'b00, S_FLUSH, 3,3));
    cyc(); stall_req = 1'b1;
    push("stall_in_flush", mk(0,0,0,0,1, 2'b00,2'b00, S_FLUSH, 3,3));
    for (int i = 0; i < 3; i++) begin
      cyc(); stall_req = 1'b1; branch_taken_ex = (i == 0); set_lu(5'd2, 5'd2, 5'd0);
      push("hold_stalled", mk(0,0,0,0,1, 2'b00,2'b00, S_HOLD, 3,3));
    end
    cyc();
    push("hold_release", mk(0,0,0,0,1, 2'b00,2'b00, S_HOLD, 3,3));
    cyc();
    push("flush_resume", mk(1,1,1,1,0, 2'b00,2'b00, S_FLUSH, 3,3));
    cyc();
    push("run_after_hold", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 3,3));

    cyc(); stall_req = 1'b1; branch_taken_ex = 1'b1;
    push("stall_over_br", mk(0,0,0,0,1, 2'b00,2'b00, S_RUN, 3,3));
    cyc(); branch_taken_ex = 1'b1;
    push("hold_last", mk(0,0,0,0,1, 2'b00,2'b00, S_HOLD, 3,3));
    cyc(); branch_taken_ex = 1'b1;
    push("br_after_hold", mk(1,1,1,1,0, 2'b00,2'b00, S_RUN, 3,3));
    cyc();
    push("post_hold_fl1", mk(1,1,1,1,0, 2'b00,2'b00, S_FLUSH, 3,4));
    cyc();
    push("post_hold_fl2", mk(1,1,1,1,0, 2'b00,2'b00, S_FLUSH, 3,4));

    for (int i = 0; i < 14; i++) begin
      cyc(); set_lu(5'd1, 5'd0, 5'd1);
      push("lu_saturate", mk(0,0,0,1,0, 2'b00,2'b00, S_RUN, (3 + i > 15) ? 15 : 3 + i, 4));
    end
    cyc();
    push("sat_hold_value", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 15,4));

    cyc(); stall_req = 1'b1;
    push("enter_hold", mk(0,0,0,0,1, 2'b00,2'b00, S_RUN, 15,4));
    cyc(); stall_req = 1'b1;
    push("in_hold", mk(0,0,0,0,1, 2'b00,2'b00, S_HOLD, 15,4));
    cyc(); stall_req = 1'b1; reset = 1'b1;
    push("async_reset_hold", mk(0,0,0,0,0, 2'b00,2'b00, S_RUN, 0,0));
    cyc(); reset = 1'b0;
    push("run_after_reset", mk(1,1,0,0,0, 2'b00,2'b00, S_RUN, 0,0));

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
